signed_div_frontend: RTL and testbench

Request front-end for the radix-4 unsigned iterative divider. It buffers tagged divide requests in a small FIFO and converts signed operands to magnitudes. It issues one operation at a time over the divider's valid/busy interface, then sign-corrects the returned quotient and remainder. It also handles divide-by-zero locally, since the divider itself never flags it. Results leave on a valid/ready port toward the consumer.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_req_fifo.sv | 72 +++++++
 rtl/signed_div_frontend.sv | 207 ++++++++++++++++++++
 tb/tb_signed_div_frontend.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the signed divider front-end:
//     div_state_t        front-end sequencing states
//     DIV_MAX_WIDTH      widest operand width the constants below cover
//     DIV_ZERO_QUOTIENT  quotient reported for divide-by-zero; sliced to WIDTH
//                        at the point of use
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUTPUT
    } div_state_t;

    localparam int unsigned DIV_MAX_WIDTH = 256;

    localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_req_fifo.sv
// ---------------------------------------------------------------------------
// div_req_fifo
//   Synchronous request FIFO with a registered occupancy count. The full and
//   empty flags come only from the registered count, so a pop in the same
//   cycle never makes room for a push in that cycle when full.
//   Ports:
//     clk_in    clock
//     rst_n_in  synchronous active-low reset (empties the FIFO)
//     push      write request (ignored when full)
//     wr_data   write data
//     pop       read request (ignored when empty)
//     rd_data   head entry (valid while !empty)
//     full      occupancy == DEPTH
//     empty     occupancy == 0
// ---------------------------------------------------------------------------
module div_req_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/signed_div_frontend.sv
// ---------------------------------------------------------------------------
// signed_div_frontend
//   Request front-end for an unsigned iterative divider. Buffers tagged
//   requests, converts signed operands to magnitudes, issues one operation at
//   a time, sign-corrects the returned quotient/remainder (truncating
//   division) and handles divide-by-zero without touching the divider.
//   Ports:
//     clk_in, rst_n_in                 clock, synchronous active-low reset
//     req_valid_in / req_ready_out     request handshake (ready = FIFO not full)
//     req_dividend_in, req_divisor_in  operands
//     req_signed_in                    1 = two's-complement operands
//     req_tag_in                       opaque tag returned with the result
//     div_dividend_out, div_divisor_out  magnitudes to divider
//     div_valid_out                    one-cycle start pulse
//     div_busy_in                      divider busy
//     div_valid_in                     divider result strobe
//     div_quotient_in, div_remainder_in  unsigned divider results
//     res_valid_out / res_ready_in     result handshake
//     res_quotient_out, res_remainder_out, res_tag_out, res_div_zero_out
// ---------------------------------------------------------------------------
module signed_div_frontend
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic [WIDTH-1:0] req_dividend_in,
    input  logic [WIDTH-1:0] req_divisor_in,
    input  logic             req_signed_in,
    input  logic [TAG_W-1:0] req_tag_in,
    output logic [WIDTH-1:0] div_dividend_out,
    output logic [WIDTH-1:0] div_divisor_out,
    output logic             div_valid_out,
    input  logic             div_busy_in,
    input  logic             div_valid_in,
    input  logic [WIDTH-1:0] div_quotient_in,
    input  logic [WIDTH-1:0] div_remainder_in,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic [WIDTH-1:0] res_quotient_out,
    output logic [WIDTH-1:0] res_remainder_out,
    output logic [TAG_W-1:0] res_tag_out,
    output logic             res_div_zero_out
);

    // Request record; its field widths follow the instance parameters.
    typedef struct packed {
        logic [WIDTH-1:0] dividend;
        logic [WIDTH-1:0] divisor;
        logic             is_signed;
        logic [TAG_W-1:0] tag;
    } div_req_t;

    localparam int unsigned REQ_W = $bits(div_req_t);

    div_state_t       state_q;
    div_state_t       state_d;

    div_req_t         push_req;
    div_req_t         head_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    logic             head_neg_dvd;
    logic             head_neg_dvs;
    logic             head_dvs_zero;
    logic [WIDTH-1:0] head_mag_dvd;
    logic [WIDTH-1:0] head_mag_dvs;

    logic             neg_dvd_q;
    logic             neg_quo_q;
    logic [WIDTH-1:0] mag_dvd_q;
    logic [WIDTH-1:0] mag_dvs_q;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] res_quo_q;
    logic [WIDTH-1:0] res_rem_q;
    logic             res_dz_q;
    logic             issue;

    always_comb begin
        push_req.dividend  = req_dividend_in;
        push_req.divisor   = req_divisor_in;
        push_req.is_signed = req_signed_in;
        push_req.tag       = req_tag_in;
    end

    div_req_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (REQ_W)
    ) u_req_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .push     (req_valid_in),
        .wr_data  (push_req),
        .pop      (fifo_pop),
        .rd_data  (head_req),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Magnitudes of the FIFO head. MIN stays MIN after negation, which as an
    // unsigned magnitude is exactly right, so MIN / -1 needs no special case.
    always_comb begin
        head_neg_dvd  = head_req.is_signed & head_req.dividend[WIDTH-1];
        head_neg_dvs  = head_req.is_signed & head_req.divisor[WIDTH-1];
        head_dvs_zero = (head_req.divisor == '0);
        head_mag_dvd  = head_neg_dvd ? -head_req.dividend : head_req.dividend;
        head_mag_dvs  = head_neg_dvs ? -head_req.divisor  : head_req.divisor;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        issue    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = head_dvs_zero ? ST_OUTPUT : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!div_busy_in) begin
                    issue   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (div_valid_in) begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (res_ready_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result registers are written only on pop (divide-by-zero) or on the
    // divider strobe, so they stay frozen throughout OUTPUT.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            neg_dvd_q <= 1'b0;
            neg_quo_q <= 1'b0;
            mag_dvd_q <= '0;
            mag_dvs_q <= '0;
            tag_q     <= '0;
            res_quo_q <= '0;
            res_rem_q <= '0;
            res_dz_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        tag_q <= head_req.tag;
                        if (head_dvs_zero) begin
                            res_quo_q <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                            res_rem_q <= head_req.dividend;
                            res_dz_q  <= 1'b1;
                        end else begin
                            neg_dvd_q <= head_neg_dvd;
                            neg_quo_q <= head_neg_dvd ^ head_neg_dvs;
                            mag_dvd_q <= head_mag_dvd;
                            mag_dvs_q <= head_mag_dvs;
                        end
                    end
                end
                ST_WAIT: begin
                    if (div_valid_in) begin
                        res_quo_q <= neg_quo_q ? -div_quotient_in  : div_quotient_in;
                        res_rem_q <= neg_dvd_q ? -div_remainder_in : div_remainder_in;
                        res_dz_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_out     = ~fifo_full;
    assign div_dividend_out  = mag_dvd_q;
    assign div_divisor_out   = mag_dvs_q;
    assign div_valid_out     = issue;
    assign res_valid_out     = (state_q == ST_OUTPUT);
    assign res_quotient_out  = res_quo_q;
    assign res_remainder_out = res_rem_q;
    assign res_tag_out       = tag_q;
    assign res_div_zero_out  = res_dz_q;

endmodule

// File: tb/tb_signed_div_frontend.sv
module tb_signed_div_frontend;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_dividend;
    logic [WIDTH-1:0] req_divisor;
    logic             req_signed;
    logic [TAG_W-1:0] req_tag;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_valid_o;
    logic             div_busy;
    logic             div_valid_i;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_quotient;
    logic [WIDTH-1:0] res_remainder;
    logic [TAG_W-1:0] res_tag;
    logic             res_div_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signed_div_frontend #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .req_valid_in      (req_valid),
        .req_ready_out     (req_ready),
        .req_dividend_in   (req_dividend),
        .req_divisor_in    (req_divisor),
        .req_signed_in     (req_signed),
        .req_tag_in        (req_tag),
        .div_dividend_out  (div_dividend),
        .div_divisor_out   (div_divisor),
        .div_valid_out     (div_valid_o),
        .div_busy_in       (div_busy),
        .div_valid_in      (div_valid_i),
        .div_quotient_in   (div_quotient),
        .div_remainder_in  (div_remainder),
        .res_valid_out     (res_valid),
        .res_ready_in      (res_ready),
        .res_quotient_out  (res_quotient),
        .res_remainder_out (res_remainder),
        .res_tag_out       (res_tag),
        .res_div_zero_out  (res_div_zero)
    );

    // Behavioural unsigned divider: busy for WIDTH/2 cycles, then one strobe.
    logic             m_busy   = 1'b0;
    logic             m_strobe = 1'b0;
    logic             inj_strobe;
    logic [WIDTH-1:0] m_a = '0;
    logic [WIDTH-1:0] m_b = '0;
    logic [WIDTH-1:0] m_q = '0;
    logic [WIDTH-1:0] m_r = '0;
    int               m_cnt = 0;
    int               pulse_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_strobe <= 1'b0;
            m_cnt    <= 0;
        end else begin
            m_strobe <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy   <= 1'b0;
                    m_strobe <= 1'b1;
                    m_q      <= m_a / m_b;
                    m_r      <= m_a % m_b;
                end
                m_cnt <= m_cnt - 1;
            end else if (div_valid_o === 1'b1) begin
                m_busy <= 1'b1;
                m_cnt  <= WIDTH / 2;
                m_a    <= div_dividend;
                m_b    <= div_divisor;
            end
        end
    end

    always @(posedge clk) begin
        if (div_valid_o === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    assign div_busy      = m_busy;
    assign div_valid_i   = m_strobe | inj_strobe;
    assign div_quotient  = m_q;
    assign div_remainder = m_r;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Starts and ends on a negedge; expects an idle front-end and divider.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                          input logic [3:0] tg, input logic [7:0] ema, input logic [7:0] emb,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz,
                          input string nm);
        int cyc = 0;
        int issue_cyc = -1;
        int strobe_cyc = -1;
        int p0;
        logic [7:0] iss_a = '0;
        logic [7:0] iss_b = '0;
        p0 = pulse_cnt;
        req_dividend = a;
        req_divisor  = b;
        req_signed   = sgn;
        req_tag      = tg;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (res_valid !== 1'b1 && cyc < 60) begin
            if (div_valid_o === 1'b1 && issue_cyc < 0) begin
                issue_cyc = cyc;
                iss_a = div_dividend;
                iss_b = div_divisor;
            end
            if (div_valid_i === 1'b1 && strobe_cyc < 0) strobe_cyc = cyc;
            @(negedge clk);
            cyc++;
        end
        check({nm, "_res_valid"}, res_valid, 1);
        check({nm, "_quotient"}, res_quotient, eq);
        check({nm, "_remainder"}, res_remainder, er);
        check({nm, "_tag"}, res_tag, tg);
        check({nm, "_div_zero"}, res_div_zero, edz);
        if (edz) begin
            check({nm, "_dz_latency"}, cyc, 2);
            check({nm, "_dz_no_issue"}, pulse_cnt - p0, 0);
        end else begin
            check({nm, "_issue_latency"}, issue_cyc, 2);
            check({nm, "_issue_dividend"}, iss_a, ema);
            check({nm, "_issue_divisor"}, iss_b, emb);
            check({nm, "_strobe_to_res"}, cyc - strobe_cyc, 1);
            check({nm, "_one_pulse"}, pulse_cnt - p0, 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({nm, "_res_valid_drop"}, res_valid, 0);
    endtask

    logic [7:0] bd [5] = '{8'd13, 8'd23, 8'd33, 8'd43, 8'd53};
    logic [7:0] bv [5] = '{8'd2,  8'd3,  8'd4,  8'd5,  8'd6};
    logic [7:0] bq [5] = '{8'd6,  8'd7,  8'd8,  8'd8,  8'd8};
    logic [7:0] br [5] = '{8'd1,  8'd2,  8'd1,  8'd3,  8'd5};

    initial begin
        int guard;
        int p0;
        logic [31:0] snap;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_dividend = '0;
        req_divisor = '0;
        req_signed = 1'b0;
        req_tag = '0;
        res_ready = 1'b0;
        inj_strobe = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_res_valid", res_valid, 0);
        check("rst_div_valid", div_valid_o, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_res_quotient", res_quotient, 0);
        check("rst_res_tag", res_tag, 0);
        check("rst_div_dividend", div_dividend, 0);
        check("rst_res_div_zero", res_div_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'hF9, 8'h02, 1'b1, 4'h3, 8'h07, 8'h02, 8'hFD, 8'hFF, 1'b0, "s_m7_by_2");
        run_op(8'hF9, 8'h02, 1'b0, 4'h5, 8'hF9, 8'h02, 8'h7C, 8'h01, 1'b0, "u_F9_by_2");
        run_op(8'h80, 8'hFF, 1'b1, 4'h9, 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, "s_min_by_m1");
        run_op(8'h07, 8'hFE, 1'b1, 4'hC, 8'h07, 8'h02, 8'hFD, 8'h01, 1'b0, "s_7_by_m2");
        run_op(8'hF8, 8'hFD, 1'b1, 4'hD, 8'h08, 8'h03, 8'h02, 8'hFE, 1'b0, "s_m8_by_m3");
        run_op(8'h35, 8'h00, 1'b0, 4'hA, 8'h00, 8'h00, 8'hFF, 8'h35, 1'b1, "u_div_zero");
        run_op(8'hF0, 8'h00, 1'b1, 4'hB, 8'h00, 8'h00, 8'hFF, 8'hF0, 1'b1, "s_div_zero");

        // Five back-to-back unsigned requests through a 4-deep FIFO.
        for (int i = 0; i < 5; i++) begin
            guard = 0;
            while (req_ready !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            req_dividend = bd[i];
            req_divisor  = bv[i];
            req_signed   = 1'b0;
            req_tag      = 4'(i + 1);
            req_valid    = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("burst_ready_low_when_full", req_ready, 0);
        for (int k = 0; k < 5; k++) begin
            guard = 0;
            while (res_valid !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check("burst_res_valid", res_valid, 1);
            check("burst_tag_order", res_tag, 32'(k + 1));
            check("burst_quotient", res_quotient, bq[k]);
            check("burst_remainder", res_remainder, br[k]);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            if (k == 0) begin
                check("burst_ready_before_pop", req_ready, 0);
                @(negedge clk);
                check("burst_ready_after_pop", req_ready, 1);
            end
        end

        // Back-pressure: hold the first result while a second request waits.
        req_dividend = 8'd100;
        req_divisor  = 8'd7;
        req_signed   = 1'b0;
        req_tag      = 4'h6;
        req_valid    = 1'b1;
        @(negedge clk);
        req_dividend = 8'h50;
        req_divisor  = 8'h10;
        req_tag      = 4'h7;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (res_valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("bp_first_valid", res_valid, 1);
        check("bp_first_quotient", res_quotient, 8'h0E);
        check("bp_first_remainder", res_remainder, 8'h02);
        check("bp_first_tag", res_tag, 4'h6);
        p0 = pulse_cnt;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            snap = {11'b0, res_valid, res_quotient, res_remainder, res_tag};
            check("bp_hold_stable", snap, {11'b0, 1'b1, 8'h0E, 8'h02, 4'h6});
        end
        check("bp_no_second_issue", pulse_cnt - p0, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        guard = 0;
        while (div_valid_o !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("bp_next_issue", div_valid_o, 1);
        check("bp_next_issue_dividend", div_dividend, 8'h50);
        guard = 0;
        while (res_valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("bp_second_quotient", res_quotient, 8'h05);
        check("bp_second_remainder", res_remainder, 8'h00);
        check("bp_second_tag", res_tag, 4'h7);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Reset while waiting on the divider, with more requests queued.
        req_dividend = 8'h64;
        req_divisor  = 8'h03;
        req_signed   = 1'b0;
        req_tag      = 4'h8;
        req_valid    = 1'b1;
        @(negedge clk);
        req_tag = 4'h9;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (div_valid_o !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("wr_issue_seen", div_valid_o, 1);
        req_tag   = 4'hA;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("wr_res_valid", res_valid, 0);
        check("wr_div_valid", div_valid_o, 0);
        check("wr_req_ready", req_ready, 1);
        rst_n = 1'b1;
        p0 = pulse_cnt;
        @(negedge clk);
        inj_strobe = 1'b1;
        @(negedge clk);
        inj_strobe = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("wr_late_strobe_ignored", res_valid, 0);
        end
        check("wr_fifo_empty_no_issue", pulse_cnt - p0, 0);

        run_op(8'hF9, 8'h02, 1'b1, 4'hF, 8'h07, 8'h02, 8'hFD, 8'hFF, 1'b0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
